// File: rtl/ms_stereo_encoder_pkg.sv
// Shared stereo definitions: Q2.14 constants, frame modes, encoder state and sample-pair helpers.
// The decode stage imports the same package.
package ms_stereo_encoder_pkg;

  localparam int N_SAMPLES = 576;
  localparam int DATA_W    = 16;
  localparam int ACC_W     = 28;
  localparam int MS_SHIFT  = 2;
  localparam int FRAC_W    = 14;

  localparam logic signed [DATA_W-1:0] SQRT_HALF = 16'sh2d41;
  localparam logic signed [DATA_W-1:0] SAT_MAX   = 16'sh7fff;
  localparam logic signed [DATA_W-1:0] SAT_MIN   = 16'sh8000;

  typedef enum logic [1:0] {STEREO = 2'b00, JOINT = 2'b01, DUAL = 2'b10, MONO = 2'b11} mode_e;
  typedef enum logic [1:0] {ST_FILL, ST_DECIDE, ST_DRAIN} enc_state_e;

  typedef struct packed {
    logic signed [DATA_W-1:0] l;
    logic signed [DATA_W-1:0] r;
  } pair_t;

  function automatic logic signed [DATA_W:0] ext_add(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return {a[DATA_W-1], a} + {b[DATA_W-1], b};
  endfunction

  function automatic logic signed [DATA_W:0] ext_sub(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return {a[DATA_W-1], a} - {b[DATA_W-1], b};
  endfunction

  // Magnitude of a widened sum; -2^DATA_W maps to 2^DATA_W, read as unsigned.
  function automatic logic [DATA_W:0] abs_w(input logic [DATA_W:0] v);
    return v[DATA_W] ? -v : v;
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_q(input logic signed [2*DATA_W:0] q);
    logic [DATA_W+1:0] hi;
    hi = q[2*DATA_W:DATA_W-1];
    if ((&hi) || !(|hi)) return q[DATA_W-1:0];
    return q[2*DATA_W] ? SAT_MIN : SAT_MAX;
  endfunction

endpackage

// File: rtl/ms_stereo_encoder_if.sv
// Sample-in / pair-out stream bundle for the joint-stereo encoder stage.
interface ms_stereo_encoder_if;
  import ms_stereo_encoder_pkg::*;

  logic [1:0]               mode_in;
  logic                     gr_in;
  logic signed [DATA_W-1:0] l_in;
  logic signed [DATA_W-1:0] r_in;
  logic                     din_v;
  logic                     din_ready;
  logic signed [DATA_W-1:0] ch1_out;
  logic signed [DATA_W-1:0] ch2_out;
  logic                     dout_v;
  logic                     last_out;
  logic                     gr_out;
  logic [1:0]               mode_ext_out;
  logic                     busy;

  modport slave (
    input  mode_in, gr_in, l_in, r_in, din_v,
    output din_ready, ch1_out, ch2_out, dout_v, last_out, gr_out, mode_ext_out, busy
  );

  modport master (
    output mode_in, gr_in, l_in, r_in, din_v,
    input  din_ready, ch1_out, ch2_out, dout_v, last_out, gr_out, mode_ext_out, busy
  );
endinterface

// File: rtl/ms_stereo_encoder_butterfly.sv
// (L,R,ms_flag) -> (ch1,ch2): M/S = (L+-R)/sqrt2 with saturation, or L/R passthrough; one register.
module ms_butterfly
  import ms_stereo_encoder_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_v,
  input  logic                     ms_flag,
  input  pair_t                    din,
  output logic signed [DATA_W-1:0] ch1,
  output logic signed [DATA_W-1:0] ch2
);
  localparam int PW = 2*DATA_W + 1;

  logic signed [DATA_W:0]   s_add, s_sub;
  logic signed [PW-1:0]     q_add, q_sub;
  logic signed [DATA_W-1:0] m, s;

  assign s_add = ext_add(din.l, din.r);
  assign s_sub = ext_sub(din.l, din.r);
  assign q_add = (PW'(s_add) * PW'(SQRT_HALF)) >>> FRAC_W;
  assign q_sub = (PW'(s_sub) * PW'(SQRT_HALF)) >>> FRAC_W;
  assign m     = sat_q(q_add);
  assign s     = sat_q(q_sub);

  // Outputs hold between valid pairs.
  always_ff @(posedge clk)
    if (rst) begin
      ch1 <= '0;
      ch2 <= '0;
    end else if (in_v) begin
      ch1 <= ms_flag ? m : din.l;
      ch2 <= ms_flag ? s : din.r;
    end
endmodule

// File: rtl/xilinx_single_port_ram_read_first.sv
// Single-port read-first block RAM; HIGH_PERFORMANCE adds an output register (2-cycle read).
module xilinx_single_port_ram_read_first #(
  parameter int RAM_WIDTH       = 32,
  parameter int RAM_DEPTH       = 576,
  parameter     RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
  input  logic [$clog2(RAM_DEPTH)-1:0] addra,
  input  logic [RAM_WIDTH-1:0]         dina,
  input  logic                         clka,
  input  logic                         wea,
  input  logic                         ena,
  input  logic                         rsta,
  input  logic                         regcea,
  output logic [RAM_WIDTH-1:0]         douta
);
  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_data;

  always_ff @(posedge clka)
    if (ena) begin
      if (wea) mem[addra] <= dina;
      ram_data <= mem[addra];
    end

  generate
    if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_no_reg
      assign douta = ram_data;
    end else begin : g_out_reg
      logic [RAM_WIDTH-1:0] douta_reg;
      always_ff @(posedge clka)
        if (rsta)        douta_reg <= '0;
        else if (regcea) douta_reg <= ram_data;
      assign douta = douta_reg;
    end
  endgenerate
endmodule

// File: rtl/ms_stereo_encoder.sv
// Joint-stereo encoder stage: buffer one granule, compare mid/side energy, then stream M/S or L/R pairs.
module ms_stereo_encoder
  import ms_stereo_encoder_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  ms_stereo_encoder_if.slave sif
);
  localparam int AW     = $clog2(N_SAMPLES);
  localparam int STAGES = 2;
  localparam int CMP_W  = ACC_W + MS_SHIFT;

  enc_state_e       state, state_nxt;
  logic [AW-1:0]    wr_cnt, rd_cnt;
  logic [ACC_W-1:0] mid_acc, side_acc;
  mode_e            mode_lat;
  logic             gr_lat, gr_o;
  logic [1:0]       mode_ext;
  logic [STAGES:0]  vld_pipe, last_pipe;
  logic             din_ready, busy, issue, wr_en, ms_flag, last_o;
  pair_t            wr_pair, rd_pair;
  logic [2*DATA_W-1:0] ram_dout;

  always_comb begin
    state_nxt = state;
    din_ready = 1'b0;
    busy      = 1'b0;
    issue     = 1'b0;
    case (state)
      ST_FILL: begin
        din_ready = 1'b1;
        if (sif.din_v && wr_cnt == AW'(N_SAMPLES-1)) state_nxt = ST_DECIDE;
      end
      ST_DECIDE: begin
        busy      = 1'b1;
        state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy  = 1'b1;
        issue = rd_cnt < AW'(N_SAMPLES);
        if (last_o) state_nxt = ST_FILL;
      end
      default: state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge clk)
    if (rst) state <= ST_FILL;
    else     state <= state_nxt;

  assign wr_en   = sif.din_v && din_ready;
  assign wr_pair = '{l: sif.l_in, r: sif.r_in};
  assign ms_flag = (mode_lat == JOINT) && ({side_acc, {MS_SHIFT{1'b0}}} < CMP_W'(mid_acc));

  always_ff @(posedge clk)
    if (rst) begin
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      mid_acc   <= '0;
      side_acc  <= '0;
      mode_lat  <= STEREO;
      gr_lat    <= 1'b0;
      gr_o      <= 1'b0;
      mode_ext  <= 2'b00;
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      // vld_pipe[0]: RAM array read, [1]: RAM output reg, [STAGES]: butterfly output.
      vld_pipe  <= {vld_pipe[STAGES-1:0], issue};
      last_pipe <= {last_pipe[STAGES-1:0], issue && rd_cnt == AW'(N_SAMPLES-1)};
      case (state)
        ST_FILL: if (wr_en) begin
          wr_cnt   <= (wr_cnt == AW'(N_SAMPLES-1)) ? '0 : wr_cnt + 1'b1;
          mid_acc  <= mid_acc  + ACC_W'(abs_w(ext_add(sif.l_in, sif.r_in)));
          side_acc <= side_acc + ACC_W'(abs_w(ext_sub(sif.l_in, sif.r_in)));
          if (wr_cnt == '0) begin
            mode_lat <= mode_e'(sif.mode_in);
            gr_lat   <= sif.gr_in;
          end
        end
        ST_DECIDE: begin
          mode_ext <= {ms_flag, 1'b0};
          gr_o     <= gr_lat;
          mid_acc  <= '0;
          side_acc <= '0;
          rd_cnt   <= '0;
        end
        ST_DRAIN: if (issue) rd_cnt <= rd_cnt + 1'b1;
        default: ;
      endcase
    end

  xilinx_single_port_ram_read_first #(
    .RAM_WIDTH      (2*DATA_W),
    .RAM_DEPTH      (N_SAMPLES),
    .RAM_PERFORMANCE("HIGH_PERFORMANCE")
  ) u_buf (
    .addra (state == ST_FILL ? wr_cnt : rd_cnt),
    .dina  (wr_pair),
    .clka  (clk),
    .wea   (wr_en),
    .ena   (1'b1),
    .rsta  (rst),
    .regcea(1'b1),
    .douta (ram_dout)
  );

  assign rd_pair = pair_t'(ram_dout);

  ms_butterfly u_bfly (
    .clk    (clk),
    .rst    (rst),
    .in_v   (vld_pipe[STAGES-1]),
    .ms_flag(mode_ext[1]),
    .din    (rd_pair),
    .ch1    (sif.ch1_out),
    .ch2    (sif.ch2_out)
  );

  assign last_o           = last_pipe[STAGES];
  assign sif.din_ready    = din_ready;
  assign sif.busy         = busy;
  assign sif.dout_v       = vld_pipe[STAGES];
  assign sif.last_out     = last_o;
  assign sif.gr_out       = gr_o;
  assign sif.mode_ext_out = mode_ext;
endmodule

// File: tb/tb_ms_stereo_encoder.sv
// Randomized granule-level bench for ms_stereo_encoder against an arithmetic reference model.
module tb_ms_stereo_encoder;
  import ms_stereo_encoder_pkg::*;

  localparam int N = N_SAMPLES;
  localparam int K_CONST = 0, K_CORR = 1, K_RAND = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ms_stereo_encoder_if sif();
  ms_stereo_encoder dut (.clk(clk), .rst(rst), .sif(sif));

  int n_chk = 0;
  int n_err = 0;
  int ml[N];
  int mr[N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic int iabs(input int v);
    return v < 0 ? -v : v;
  endfunction

  task automatic gen(input int kind, input int a, input int b, output int l, output int r);
    case (kind)
      K_CONST: begin l = a; r = b; end
      K_CORR: begin
        l = int'($urandom_range(0, 16000)) - 8000;
        r = l + int'($urandom_range(0, 400)) - 200;
      end
      default: begin
        l = int'($signed(16'($urandom)));
        r = int'($signed(16'($urandom)));
      end
    endcase
  endtask

  task automatic run_granule(input string name, input int mode, input bit gr, input int kind,
                             input int a, input int b, input int gap_pct, input bit hold_v,
                             input int rst_after);
    int idx, guard, k, first_k, last_k, n_last, last_at, bad, l, r, e1, e2;
    longint mid, side;
    bit ms;
    int g1[$];
    int g2[$];
    idx = 0; guard = 0;
    while (idx < N && guard < 20*N) begin
      @(negedge clk);
      guard++;
      if (sif.din_ready && int'($urandom_range(0, 99)) >= gap_pct) begin
        gen(kind, a, b, l, r);
        ml[idx] = l; mr[idx] = r;
        sif.din_v   = 1'b1;
        sif.l_in    = 16'(l);
        sif.r_in    = 16'(r);
        sif.mode_in = (idx == 0) ? 2'(mode) : 2'($urandom);
        sif.gr_in   = (idx == 0) ? gr : 1'($urandom);
        idx++;
      end else begin
        sif.din_v = 1'b0;
      end
    end
    if (idx < N) chk({name, " feed_timeout"}, idx, N);

    mid = 0; side = 0;
    for (int i = 0; i < N; i++) begin
      mid  += iabs(ml[i] + mr[i]);
      side += iabs(ml[i] - mr[i]);
    end
    ms = (mode == 1) && (4*side < mid);

    k = 0; first_k = -1; last_k = -1; n_last = 0; last_at = -1; bad = 0;
    while (k < N + 50) begin
      @(negedge clk);
      k++;
      if (last_k >= 0) begin
        sif.din_v = 1'b0;
        chk({name, " rdy_after_last"}, sif.din_ready, 1);
        chk({name, " busy_after_last"}, sif.busy, 0);
        chk({name, " dv_after_last"}, sif.dout_v, 0);
        if (g1.size() > 0) chk({name, " ch1_hold"}, 32'(int'(sif.ch1_out)), 32'(g1[g1.size()-1]));
        break;
      end
      sif.din_v = hold_v;
      sif.l_in  = 16'($urandom);
      sif.r_in  = 16'($urandom);
      sif.mode_in = 2'($urandom);
      if (!sif.busy || sif.din_ready) bad++;
      if (sif.dout_v) begin
        g1.push_back(int'(sif.ch1_out));
        g2.push_back(int'(sif.ch2_out));
        if (first_k < 0) first_k = k;
      end
      if (sif.last_out) begin
        n_last++;
        last_k  = k;
        last_at = g1.size();
      end
      if (rst_after > 0 && g1.size() == rst_after) begin
        rst = 1'b1;
        sif.din_v = 1'b0;
        @(negedge clk);
        chk({name, " rst_dv"}, sif.dout_v, 0);
        chk({name, " rst_rdy"}, sif.din_ready, 1);
        chk({name, " rst_mode_ext"}, sif.mode_ext_out, 0);
        chk({name, " rst_busy"}, sif.busy, 0);
        chk({name, " rst_last"}, sif.last_out, 0);
        rst = 1'b0;
        return;
      end
    end

    chk({name, " n_out"}, g1.size(), N);
    chk({name, " n_last"}, n_last, 1);
    chk({name, " last_index"}, last_at, N);
    chk({name, " first_latency"}, first_k, 5);
    chk({name, " contiguous"}, last_k - first_k + 1, N);
    chk({name, " rdy_while_busy"}, bad, 0);
    chk({name, " mode_ext"}, sif.mode_ext_out, {ms, 1'b0});
    chk({name, " gr_out"}, sif.gr_out, gr);
    for (int i = 0; i < N && i < g1.size(); i++) begin
      e1 = ms ? sat16((longint'(ml[i] + mr[i]) * 11585) >>> 14) : ml[i];
      e2 = ms ? sat16((longint'(ml[i] - mr[i]) * 11585) >>> 14) : mr[i];
      chk($sformatf("%s ch1[%0d]", name, i), g1[i], e1);
      chk($sformatf("%s ch2[%0d]", name, i), g2[i], e2);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    sif.din_v = 1'b0; sif.l_in = '0; sif.r_in = '0; sif.mode_in = '0; sif.gr_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset din_ready", sif.din_ready, 1);
    chk("reset dout_v", sif.dout_v, 0);
    chk("reset last_out", sif.last_out, 0);
    chk("reset ch1", sif.ch1_out, 0);
    chk("reset ch2", sif.ch2_out, 0);
    chk("reset gr_out", sif.gr_out, 0);
    chk("reset mode_ext", sif.mode_ext_out, 0);
    chk("reset busy", sif.busy, 0);
    rst = 1'b0;

    run_granule("ms_equal",   1, 1'b0, K_CONST, 16'sh1000, 16'sh1000, 0, 1'b0, 0);
    run_granule("lr_opposed", 1, 1'b1, K_CONST, 4096, -4096, 20, 1'b0, 0);
    run_granule("forced_lr",  0, 1'b0, K_CONST, 4096, 4096, 10, 1'b0, 0);
    run_granule("bnd_equal",  1, 1'b1, K_CONST, 5, 3, 0, 1'b0, 0);
    run_granule("bnd_above",  1, 1'b0, K_CONST, 6, 4, 0, 1'b0, 0);
    run_granule("sat_pos",    1, 1'b1, K_CONST, 32767, 32767, 0, 1'b0, 0);
    run_granule("sat_neg",    1, 1'b0, K_CONST, -32768, -32768, 0, 1'b0, 0);
    run_granule("hold_v",     1, 1'b1, K_CORR, 0, 0, 0, 1'b1, 0);
    run_granule("mid_rst",    1, 1'b1, K_CORR, 0, 0, 0, 1'b1, 100);
    run_granule("post_rst",   1, 1'b0, K_CORR, 0, 0, 30, 1'b0, 0);
    for (int g = 0; g < 4; g++)
      run_granule($sformatf("rand%0d", g), int'($urandom_range(0, 3)), 1'($urandom),
                  int'($urandom_range(K_CORR, K_RAND)), 0, 0, int'($urandom_range(0, 40)),
                  1'($urandom), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
